// File: rtl/conv1d_sram_arb_pkg.sv
// conv1d_sram_arb_pkg
// Shared definitions for the conv1d SRAM arbitration logic.
//   DataWidth / BeWidth   : SRAM word and byte-enable widths.
//   AddrWidth             : default word-address width of the conv1d SRAM.
//   conv1d_sram_req_t     : one requester's access fields bundled together.
//   wrap_inc()            : modulo increment that is safe for any requester
//                           count, including non-powers of two.
package conv1d_sram_arb_pkg;

  localparam int DataWidth = 32;
  localparam int BeWidth   = 4;
  localparam int AddrWidth = 7;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } conv1d_sram_req_t;

  // Increment an index and wrap explicitly at num, so a pointer never
  // lands on an index with no requester behind it.
  function automatic int wrap_inc(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/conv1d_rr_picker.sv
// conv1d_rr_picker
// Purely combinational round-robin winner search.
//   req_i   : request vector, one bit per requester.
//   ptr_i   : highest-priority index for this cycle (must be < NUM_REQ).
//   gnt_o   : one-hot grant of the winner, zero when nobody requests.
//   idx_o   : binary index of the winner (0 when valid_o is low).
//   valid_o : at least one request is present.
module conv1d_rr_picker #(
  parameter  int NUM_REQ  = 3,
  localparam int IdxWidth = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  // Walk the candidates from the farthest offset back to the pointer so
  // the candidate closest to the pointer is the last one written and
  // therefore wins. The candidate index wraps by subtraction, which keeps
  // it legal for requester counts that are not powers of two.
  always_comb begin
    int                  cand;
    logic [IdxWidth-1:0] candIdx;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      candIdx = IdxWidth'(cand);
      if (req_i[candIdx]) begin
        gnt_o          = '0;
        gnt_o[candIdx] = 1'b1;
        idx_o          = candIdx;
        valid_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv1d_sram_arbiter.sv
// conv1d_sram_arbiter
// Shares one single-port, 1-cycle-latency SRAM between NUM_REQ masters
// with round-robin priority, and counts contended cycles for debug.
//   clk_i, rst_i         : clock and synchronous active-high reset.
//   req_i/we_i/addr_i/
//   wdata_i/be_i         : per-requester access fields (flattened vectors,
//                          requester k occupies slice k).
//   gnt_o                : one-hot grant, combinational, same cycle.
//   rvalid_o             : one-hot response valid, one cycle after grant.
//   rdata_o              : SRAM read data broadcast to all requesters.
//   sram_*               : the single SRAM port.
//   cnt_clear_i          : clears the contention counter.
//   conflict_cnt_o       : saturating count of cycles with >=2 requests.
module conv1d_sram_arbiter
  import conv1d_sram_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 3,
  parameter  int NUM_WORDS = 128,
  parameter  int CNT_WIDTH = 16,
  localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int IdxWidth  = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*AddrWidth-1:0]   addr_i,
  input  logic [NUM_REQ*DataWidth-1:0]   wdata_i,
  input  logic [NUM_REQ*BeWidth-1:0]     be_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [AddrWidth-1:0]           sram_addr_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  output logic [BeWidth-1:0]             sram_be_o,
  input  logic [DataWidth-1:0]           sram_rdata_i,
  input  logic                           cnt_clear_i,
  output logic [CNT_WIDTH-1:0]           conflict_cnt_o
);

  logic [IdxWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 rvalid_q;
  logic [IdxWidth-1:0]  rid_q;
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [IdxWidth-1:0]  winIdx;
  logic                 pickValid;
  logic                 contended;

  // Winner search starting at the round-robin pointer.
  conv1d_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt_o),
    .idx_o   (winIdx),
    .valid_o (pickValid)
  );

  // Steer the winner's fields onto the SRAM port; an idle cycle drives all
  // zeros so the macro sees a clean, quiet bus.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (pickValid) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i[winIdx];
      sram_addr_o  = addr_i[int'(winIdx)*AddrWidth +: AddrWidth];
      sram_wdata_o = wdata_i[int'(winIdx)*DataWidth +: DataWidth];
      sram_be_o    = be_i[int'(winIdx)*BeWidth +: BeWidth];
    end
  end

  // Next pointer is one past the winner so the winner drops to lowest
  // priority; with no grant the pointer keeps its place.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pickValid) begin
      rr_ptr_d = IdxWidth'(wrap_inc(int'(winIdx), NUM_REQ));
    end
  end

  // Contention counter: clear beats increment, and the count sticks at
  // all-ones instead of wrapping back to a misleadingly small value.
  assign contended = ($countones(req_i) >= 2);

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (cnt_clear_i) begin
      conflict_cnt_d = '0;
    end else if (contended && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers. Reset drops any in-flight response, so a grant seen
  // in the reset cycle never produces an rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q       <= '0;
      rvalid_q       <= 1'b0;
      rid_q          <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rvalid_q       <= pickValid;
      conflict_cnt_q <= conflict_cnt_d;
      if (pickValid) begin
        rid_q <= winIdx;
      end
    end
  end

  // Response routing: the SRAM returns data one cycle after the access,
  // which lines up with the registered winner index.
  assign rvalid_o       = rvalid_q ? (NUM_REQ'(1) << rid_q) : '0;
  assign rdata_o        = sram_rdata_i;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_conv1d_sram_arbiter.sv
// tb_conv1d_sram_arbiter
// Directed scenarios followed by random traffic, checked against a
// behavioural model of round-robin arbitration, memory contents and the
// contention counter. A second instance with a 2-bit counter covers
// saturation.
module tb_conv1d_sram_arbiter;

  localparam int NR = 3;
  localparam int AW = 7;
  localparam int NW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req, we;
  logic [NR*AW-1:0]  addr;
  logic [NR*32-1:0]  wdata;
  logic [NR*4-1:0]   be;
  logic              cntClear;

  logic [NR-1:0]     gnt, rvalid;
  logic [31:0]       rdata;
  logic              sramReq, sramWe;
  logic [AW-1:0]     sramAddr;
  logic [31:0]       sramWdata;
  logic [3:0]        sramBe;
  logic [31:0]       sramRdata;
  logic [15:0]       cnt;

  logic [NR-1:0]     satGnt, satRvalid;
  logic [31:0]       satRdata;
  logic              satSramReq, satSramWe;
  logic [AW-1:0]     satSramAddr;
  logic [31:0]       satSramWdata;
  logic [3:0]        satSramBe;
  logic [1:0]        satCnt;

  int assertCount = 0;
  int failCount   = 0;

  conv1d_sram_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .sram_req_o(sramReq), .sram_we_o(sramWe),
    .sram_addr_o(sramAddr), .sram_wdata_o(sramWdata), .sram_be_o(sramBe),
    .sram_rdata_i(sramRdata), .cnt_clear_i(cntClear), .conflict_cnt_o(cnt)
  );

  conv1d_sram_arbiter #(.CNT_WIDTH(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(satGnt), .rvalid_o(satRvalid),
    .rdata_o(satRdata), .sram_req_o(satSramReq), .sram_we_o(satSramWe),
    .sram_addr_o(satSramAddr), .sram_wdata_o(satSramWdata), .sram_be_o(satSramBe),
    .sram_rdata_i(32'h0), .cnt_clear_i(cntClear), .conflict_cnt_o(satCnt)
  );

  // Behavioural single-port SRAM with one cycle of read latency.
  logic [31:0] sramMem [NW];
  always @(posedge clk) begin
    if (sramReq) begin
      sramRdata <= sramMem[sramAddr];
      if (sramWe) begin
        for (int b = 0; b < 4; b++) begin
          if (sramBe[b]) sramMem[sramAddr][8*b +: 8] <= sramWdata[8*b +: 8];
        end
      end
    end
  end

  // Reference model state.
  logic [31:0] gold [NW];
  int          mPtr;
  bit          mPrevValid;
  int          mPrevIdx;
  bit          mPrevWe;
  logic [31:0] mPrevData;
  int          mCnt;
  int          mCntSat;

  // First requester at or after the pointer, going round the ring.
  function automatic int pickWinner(input logic [NR-1:0] r, input int p);
    for (int off = 0; off < NR; off++) begin
      if (r[(p + off) % NR]) return (p + off) % NR;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model for the current cycle.
  task automatic checkAll();
    int w;
    logic [NR-1:0] expGnt, expRv;
    w      = pickWinner(req, mPtr);
    expGnt = (w >= 0) ? (NR'(1) << w) : '0;
    expRv  = mPrevValid ? (NR'(1) << mPrevIdx) : '0;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("sram_req", 32'(sramReq), 32'(w >= 0));
    if (w >= 0) begin
      checkOutput("sram_we", 32'(sramWe), 32'(we[w]));
      checkOutput("sram_addr", 32'(sramAddr), 32'(addr[w*AW +: AW]));
      checkOutput("sram_wdata", sramWdata, wdata[w*32 +: 32]);
      checkOutput("sram_be", 32'(sramBe), 32'(be[w*4 +: 4]));
    end else begin
      checkOutput("sram_idle", {sramWe, 3'b0, sramBe, 17'(sramAddr)} | sramWdata, 32'h0);
    end
    checkOutput("rvalid", 32'(rvalid), 32'(expRv));
    if (mPrevValid && !mPrevWe) checkOutput("rdata", rdata, mPrevData);
    checkOutput("cnt", 32'(cnt), 32'(mCnt));
    checkOutput("cnt_sat", 32'(satCnt), 32'(mCntSat));
  endtask

  // Advance the model across one clock edge.
  task automatic modelUpdate();
    int w, pop;
    logic [AW-1:0] a;
    logic [31:0] readVal;
    w = pickWinner(req, mPtr);
    pop = $countones(req);
    readVal = '0;
    if (w >= 0) begin
      a = addr[w*AW +: AW];
      readVal = gold[a];
      if (we[w]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[w*4 + b]) gold[a][8*b +: 8] = wdata[w*32 + 8*b +: 8];
        end
      end
    end
    if (rst) begin
      mPtr = 0; mPrevValid = 0; mPrevIdx = 0; mCnt = 0; mCntSat = 0;
    end else begin
      if (w >= 0) begin
        mPtr = (w + 1) % NR; mPrevValid = 1; mPrevIdx = w;
        mPrevWe = we[w]; mPrevData = readVal;
      end else begin
        mPrevValid = 0;
      end
      if (cntClear) begin
        mCnt = 0; mCntSat = 0;
      end else if (pop >= 2) begin
        if (mCnt < 65535) mCnt++;
        if (mCntSat < 3) mCntSat++;
      end
    end
  endtask

  // Inputs are set just after a rising edge; checks run on the falling edge.
  task automatic runCycle();
    @(negedge clk);
    checkAll();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic w, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    req[k] = 1'b1;
    we[k] = w;
    addr[k*AW +: AW] = a;
    wdata[k*32 +: 32] = d;
    be[k*4 +: 4] = b;
  endtask

  task automatic clearInputs();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      sramMem[i] = $urandom;
    end
    sramMem[5] = 32'hDEADBEEF;
    sramMem[9] = 32'hAABBCCDD;
    for (int i = 0; i < NW; i++) gold[i] = sramMem[i];
    sramRdata = '0;
    mPrevWe = 0; mPrevData = '0;

    rst = 1'b1; cntClear = 1'b0; clearInputs();
    @(posedge clk); #1;
    mPtr = 0; mPrevValid = 0; mPrevIdx = 0; mCnt = 0; mCntSat = 0;
    rst = 1'b0;
    checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
    checkOutput("reset_cnt", 32'(cnt), 32'h0);
    runCycle();

    $display("[TB] single requester read");
    clearInputs(); applyStimulus(1, 1'b0, 7'd5, 32'h0, 4'hF);
    #1 checkOutput("t1_gnt", 32'(gnt), 32'b010);
    runCycle();
    clearInputs();
    checkOutput("t1_rvalid", 32'(rvalid), 32'b010);
    checkOutput("t1_rdata", rdata, 32'hDEADBEEF);
    checkOutput("t1_cnt", 32'(cnt), 32'h0);
    runCycle();

    $display("[TB] three requesters from reset");
    rst = 1'b1; runCycle(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clearInputs();
      for (int k = 0; k < NR; k++) applyStimulus(k, 1'b0, 7'($urandom_range(0, 127)), 32'h0, 4'hF);
      #1 checkOutput("t2_gnt", 32'(gnt), 32'(NR'(1) << (i % 3)));
      runCycle();
    end
    clearInputs();
    checkOutput("t2_cnt6", 32'(cnt), 32'd6);
    checkOutput("t2_rvalid", 32'(rvalid), 32'b100);
    runCycle();

    $display("[TB] write then read");
    applyStimulus(0, 1'b1, 7'd9, 32'h11223344, 4'b0011);
    runCycle();
    clearInputs(); applyStimulus(0, 1'b0, 7'd9, 32'h0, 4'hF);
    runCycle();
    clearInputs();
    checkOutput("t3_rdata", rdata, 32'hAABB3344);
    runCycle();

    $display("[TB] reset drops pending response");
    applyStimulus(1, 1'b0, 7'd3, 32'h0, 4'hF);
    runCycle();
    clearInputs(); rst = 1'b1;
    runCycle();
    rst = 1'b0;
    checkOutput("t4_rvalid_a", 32'(rvalid), 32'h0);
    for (int k = 0; k < NR; k++) applyStimulus(k, 1'b0, 7'd1, 32'h0, 4'hF);
    runCycle();
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    checkOutput("t4_rvalid_b", 32'(rvalid), 32'h0);
    #1 checkOutput("t4_gnt0", 32'(gnt), 32'b001);
    runCycle();
    clearInputs(); runCycle();

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 5; i++) begin
      clearInputs();
      applyStimulus(0, 1'b0, 7'd2, 32'h0, 4'hF);
      applyStimulus(1, 1'b0, 7'd4, 32'h0, 4'hF);
      runCycle();
    end
    checkOutput("t5_sat3", 32'(satCnt), 32'd3);
    cntClear = 1'b1;
    runCycle();
    cntClear = 1'b0; clearInputs();
    checkOutput("t5_clear", 32'(satCnt), 32'd0);
    checkOutput("t5_clear_main", 32'(cnt), 32'd0);
    runCycle();

    $display("[TB] pointer wrap and withdrawn request");
    applyStimulus(2, 1'b0, 7'd6, 32'h0, 4'hF);
    #1 checkOutput("t6_gnt2", 32'(gnt), 32'b100);
    runCycle();
    clearInputs();
    applyStimulus(0, 1'b0, 7'd7, 32'h0, 4'hF);
    applyStimulus(2, 1'b0, 7'd8, 32'h0, 4'hF);
    #1 checkOutput("t6_gnt0", 32'(gnt), 32'b001);
    runCycle();
    clearInputs();
    applyStimulus(0, 1'b1, 7'd10, 32'h12345678, 4'hF);
    applyStimulus(1, 1'b0, 7'd11, 32'h0, 4'hF);
    runCycle();
    clearInputs();
    runCycle();
    checkOutput("t6_no_rvalid", 32'(rvalid), 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      cntClear = ($urandom_range(0, 19) == 0);
      clearInputs();
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          applyStimulus(k, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                        $urandom, 4'($urandom_range(0, 15)));
        end
      end
      runCycle();
    end
    rst = 1'b0; cntClear = 1'b0; clearInputs();
    runCycle();
    runCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
